rr_arb_lock: RTL and testbench

- Registered round-robin arbiter for N requesters; parametrised, stateful successor to the combinational programmable-priority encoder.
- Holds its own rotating priority pointer, advanced past each winner.
- Adds a bounded lock mode: a requester keeps its grant across cycles for multi-cycle transfers.
- Sits in front of shared resources: buffer write ports, crossbar outputs.

---
 rtl/rr_arb_lock_if.sv | 14 +
 rtl/rr_arb_lock.sv | 63 ++++++
 tb/tb_rr_arb_lock.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rr_arb_lock_if.sv
// rr_arb_lock_if: request/lock/grant bundle between requesters and the round-robin arbiter.
interface rr_arb_lock_if #(
    parameter int N = 4,
    parameter int PW = $clog2(N)
);
    logic en;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] gnt;
    logic any_gnt;
    logic [PW-1:0] gnt_idx;
    modport master (output en, req, lock, input gnt, any_gnt, gnt_idx);
    modport slave (input en, req, lock, output gnt, any_gnt, gnt_idx);
endinterface

// File: rtl/rr_arb_lock.sv
// rr_arb_lock: registered round-robin arbiter with a rotating pointer and bounded grant lock.
module rr_arb_lock #(
    parameter int N = 4,
    parameter int PW = $clog2(N),
    parameter int MAX_HOLD = 4
) (
    input logic clk,
    input logic rst,
    rr_arb_lock_if.slave arb
);
    localparam int HW = MAX_HOLD > 2 ? $clog2(MAX_HOLD) : 1;
    logic [N-1:0] r_gnt;
    logic [PW-1:0] r_idx;
    logic [PW-1:0] r_ptr;
    logic [HW-1:0] r_hold;
    logic r_any;
    logic [PW-1:0] w_j;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_ptr_nxt;
    logic w_found;
    logic w_keep;

    always_comb begin
        w_found = 1'b0;
        w_win = '0;
        w_j = '0;
        for (int k = 0; k < N; k++) begin
            w_j = PW'((int'(r_ptr) + k) % N);
            if (!w_found && arb.req[w_j]) begin
                w_found = 1'b1;
                w_win = w_j;
            end
        end
        w_ptr_nxt = (int'(w_win) == N - 1) ? '0 : w_win + 1'b1;
        // hold_cnt counts extra cycles beyond the granting one
        w_keep = r_any && (MAX_HOLD > 0) && arb.req[r_idx] && arb.lock[r_idx]
                 && (int'(r_hold) < MAX_HOLD - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt <= '0;
            r_idx <= '0;
            r_any <= 1'b0;
            r_ptr <= '0;
            r_hold <= '0;
        end else if (arb.en) begin
            if (w_keep) begin
                r_hold <= r_hold + 1'b1;
            end else begin
                r_gnt <= N'(w_found) << w_win;
                r_idx <= w_win;
                r_any <= w_found;
                r_ptr <= w_found ? w_ptr_nxt : r_ptr;
                r_hold <= '0;
            end
        end
    end

    assign arb.gnt = r_gnt;
    assign arb.gnt_idx = r_idx;
    assign arb.any_gnt = r_any;
endmodule

// File: tb/tb_rr_arb_lock.sv
// tb_rr_arb_lock: two arbiters (MAX_HOLD=4 and MAX_HOLD=0) under shared stimulus, checked
// every cycle against a holder/age model, plus literal expectations from hand-worked sequences.
module tb_rr_arb_lock;
    localparam int N = 4;
    localparam int MH [2] = '{4, 0};
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] lock = '0;
    int n_checks = 0;
    int n_fail = 0;
    int m_own [2] = '{-1, -1};
    int m_ptr [2] = '{0, 0};
    int m_age [2] = '{0, 0};

    always #5 clk = ~clk;

    rr_arb_lock_if #(.N(N)) if0 ();
    rr_arb_lock_if #(.N(N)) if1 ();
    assign if0.en = en;
    assign if0.req = req;
    assign if0.lock = lock;
    assign if1.en = en;
    assign if1.req = req;
    assign if1.lock = lock;

    rr_arb_lock #(.N(N), .MAX_HOLD(4)) dut0 (.clk(clk), .rst(rst), .arb(if0));
    rr_arb_lock #(.N(N), .MAX_HOLD(0)) dut1 (.clk(clk), .rst(rst), .arb(if1));

    function automatic int arb_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // model: the holder keeps its grant while it requests+locks and has been granted < MAX_HOLD cycles
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_own[d] <= -1;
                m_ptr[d] <= 0;
                m_age[d] <= 0;
            end else if (en) begin
                if (m_own[d] >= 0 && MH[d] > 0 && req[m_own[d]] && lock[m_own[d]] && m_age[d] < MH[d]) begin
                    m_age[d] <= m_age[d] + 1;
                end else if (req != 0) begin
                    m_own[d] <= arb_pick(req, m_ptr[d]);
                    m_ptr[d] <= (arb_pick(req, m_ptr[d]) + 1) % N;
                    m_age[d] <= 1;
                end else begin
                    m_own[d] <= -1;
                    m_age[d] <= 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] mg(input int d);
        return m_own[d] < 0 ? 4'b0000 : 4'(1 << m_own[d]);
    endfunction

    function automatic logic [3:0] mi(input int d);
        return m_own[d] < 0 ? 4'd0 : 4'(m_own[d]);
    endfunction

    always @(negedge clk) begin
        chk("model gnt0", if0.gnt, mg(0));
        chk("model idx0", {2'b00, if0.gnt_idx}, mi(0));
        chk("model any0", {3'b000, if0.any_gnt}, {3'b000, m_own[0] >= 0});
        chk("model gnt1", if1.gnt, mg(1));
        chk("model idx1", {2'b00, if1.gnt_idx}, mi(1));
        chk("model any1", {3'b000, if1.any_gnt}, {3'b000, m_own[1] >= 0});
    end

    task automatic step(input logic e, input logic [3:0] r, input logic [3:0] l);
        @(negedge clk);
        en = e;
        req = r;
        lock = l;
        @(posedge clk);
        #1;
    endtask

    task automatic expect0(input string nm, input logic [3:0] g, input logic [3:0] i);
        chk({nm, " gnt"}, if0.gnt, g);
        chk({nm, " idx"}, {2'b00, if0.gnt_idx}, i);
        chk({nm, " any"}, {3'b000, if0.any_gnt}, {3'b000, |g});
    endtask

    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] sp [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
    logic [3:0] d1 [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] r;
    logic [3:0] l;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect0("reset", 4'b0000, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 4'b1111, 4'b0000);
        expect0("first", 4'b0001, 4'd0);
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000);
        expect0("pre-rst", 4'b0100, 4'd2);
        #2 rst = 1'b1;
        #1 expect0("async rst", 4'b0000, 4'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1111, 4'b0000);
            expect0("fair", seq[i], 4'(i % 4));
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b0101, 4'b0000);
            expect0("sparse", sp[i], sp[i] == 4'b0100 ? 4'd2 : 4'd0);
        end
        step(1'b1, 4'b0000, 4'b0000);
        expect0("idle", 4'b0000, 4'd0);
        step(1'b1, 4'b1111, 4'b0000);
        expect0("ptr kept", 4'b0010, 4'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b1111, 4'b0010);
            expect0("lock", i < 3 ? 4'b0010 : 4'b0100, i < 3 ? 4'd1 : 4'd2);
            chk("nolock gnt", if1.gnt, d1[i]);
        end
        step(1'b1, 4'b1111, 4'b0010);
        expect0("rot a", 4'b1000, 4'd3);
        step(1'b1, 4'b1111, 4'b0010);
        expect0("rot b", 4'b0001, 4'd0);
        step(1'b1, 4'b1111, 4'b0010);
        expect0("hold1", 4'b0010, 4'd1);
        step(1'b1, 4'b1111, 4'b0010);
        expect0("hold1 keep", 4'b0010, 4'd1);
        step(1'b1, 4'b1001, 4'b0010);
        expect0("early rel", 4'b1000, 4'd3);
        step(1'b1, 4'b0010, 4'b0000);
        expect0("pre-freeze", 4'b0010, 4'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b1100, 4'b0000);
            expect0("freeze", 4'b0010, 4'd1);
        end
        step(1'b1, 4'b1100, 4'b0000);
        expect0("unfreeze", 4'b0100, 4'd2);
        for (int i = 0; i < 3000; i++) begin
            r = 4'($urandom);
            l = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = r | 4'($urandom);
            if (m_own[0] >= 0 && $urandom_range(0, 9) < 7) begin
                r[2'(m_own[0])] = 1'b1;
                l[2'(m_own[0])] = 1'b1;
            end
            step($urandom_range(0, 9) != 0, r, l);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
